// File: rtl/spi_fpga_regif_pkg.sv
// Shared constants and FSM encoding for the SPI slave register interface.
package spi_fpga_regif_pkg;

   localparam int   ADDR_W_DEF = 7;
   localparam int   DATA_W_DEF = 8;
   localparam logic RW_READ    = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } regif_state_t;

endpackage

// File: rtl/spi_fpga_regif_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI line with edge pulses
// taken from the two most recent settled samples.
module spi_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= {STAGES{RESET_VAL}};
      end else begin
         sync <= {sync[STAGES-2:0], din};
      end
   end

   assign level = sync[STAGES-2];
   assign rise  = sync[STAGES-2] & ~sync[STAGES-1];
   assign fall  = ~sync[STAGES-2] & sync[STAGES-1];

endmodule

// File: rtl/spi_fpga_regif.sv
// SPI mode-0 slave that decodes {rw, addr, data} frames into single-cycle
// register-bus strobes and returns read data on MISO during the data phase.
module spi_fpga_regif
   import spi_fpga_regif_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_sclk,
   input  logic              fpga_cs,
   input  logic              fpga_mosi,
   output logic              fpga_miso,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_wr_en,
   output logic              reg_rd_en,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              frame_err
);

   localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
   localparam int SH_W      = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
   localparam logic [4:0] LAST_CMD_BIT  = 5'(ADDR_W);
   localparam logic [4:0] LAST_BIT      = 5'(FRAME_LEN - 1);
   localparam logic [4:0] TX_SHIFT_FROM = 5'(ADDR_W + 2);

   logic sclk_level, sclk_rise, sclk_fall;
   logic cs_level, cs_rise, cs_fall;
   logic mosi, mosi_rise, mosi_fall;
   logic unused_edges;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .din(spi_sclk),
      .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
   );
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .din(fpga_cs),
      .level(cs_level), .rise(cs_rise), .fall(cs_fall)
   );
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .din(fpga_mosi),
      .level(mosi), .rise(mosi_rise), .fall(mosi_fall)
   );

   assign unused_edges = ^{sclk_level, mosi_rise, mosi_fall};

   regif_state_t      state;
   logic [4:0]        bit_cnt;
   logic [SH_W-1:0]   rx_shift;
   logic [DATA_W-1:0] tx_shift;
   logic              tx_valid;
   logic              rw;
   logic              rd_pend;
   logic              armed;
   logic [SYNC_STAGES-1:0] settle;
   logic              last_rise;

   assign last_rise = (state == ST_DATA) && sclk_rise && (bit_cnt == LAST_BIT);
   assign fpga_miso = (state == ST_DATA) && rw && tx_valid && tx_shift[DATA_W-1];

   // A CS fall only counts once CS has been seen high on real samples after
   // reset, so a release with CS already low cannot start a bogus frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         tx_valid  <= 1'b0;
         rw        <= 1'b0;
         rd_pend   <= 1'b0;
         armed     <= 1'b0;
         settle    <= '0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_wr_en <= 1'b0;
         reg_rd_en <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         reg_wr_en <= 1'b0;
         reg_rd_en <= 1'b0;
         frame_err <= 1'b0;
         rd_pend   <= reg_rd_en;
         settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
         if (settle[SYNC_STAGES-1] && cs_level) begin
            armed <= 1'b1;
         end

         if (cs_fall && armed) begin
            state    <= ST_CMD;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            tx_valid <= 1'b0;
            rw       <= 1'b0;
         end else if (cs_rise) begin
            if (last_rise) begin
               if (rw != RW_READ) begin
                  reg_wr_en <= 1'b1;
                  reg_wdata <= {rx_shift[DATA_W-2:0], mosi};
               end
            end else if (state == ST_CMD || state == ST_DATA) begin
               frame_err <= 1'b1;
            end
            state    <= ST_IDLE;
            tx_valid <= 1'b0;
         end else begin
            case (state)
               ST_CMD: begin
                  if (sclk_rise) begin
                     bit_cnt  <= bit_cnt + 5'd1;
                     rx_shift <= {rx_shift[SH_W-2:0], mosi};
                     if (bit_cnt == LAST_CMD_BIT) begin
                        rw        <= rx_shift[ADDR_W-1];
                        reg_addr  <= {rx_shift[ADDR_W-2:0], mosi};
                        reg_rd_en <= (rx_shift[ADDR_W-1] == RW_READ);
                        state     <= ST_DATA;
                     end
                  end
               end
               // The first data bit is held through its own sampling rise, so
               // falls only shift once that rise has been counted.
               ST_DATA: begin
                  if (rd_pend) begin
                     tx_shift <= reg_rdata;
                     tx_valid <= 1'b1;
                  end else if (sclk_fall && tx_valid && bit_cnt >= TX_SHIFT_FROM) begin
                     tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                  end
                  if (sclk_rise) begin
                     bit_cnt  <= bit_cnt + 5'd1;
                     rx_shift <= {rx_shift[SH_W-2:0], mosi};
                     if (bit_cnt == LAST_BIT) begin
                        if (rw != RW_READ) begin
                           reg_wr_en <= 1'b1;
                           reg_wdata <= {rx_shift[DATA_W-2:0], mosi};
                        end
                        tx_valid <= 1'b0;
                        state    <= ST_DONE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_fpga_regif.sv
// Directed self-checking bench for spi_fpga_regif: SPI master tasks, a
// registered register-bus slave model, and strobe monitors.
module tb_spi_fpga_regif;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spi_sclk = 1'b0;
   logic       fpga_cs = 1'b1;
   logic       fpga_mosi = 1'b0;
   logic       fpga_miso;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_wr_en;
   logic       reg_rd_en;
   logic [7:0] reg_rdata = 8'hEE;
   logic       frame_err;

   logic [7:0] rd_value = 8'h3C;

   int n_compared = 0;
   int n_mismatched = 0;

   int         wr_cnt = 0, rd_cnt = 0, err_cnt = 0, miso_hi_cnt = 0;
   logic [6:0] last_wr_addr = '0, last_rd_addr = '0;
   logic [7:0] last_wdata = '0;

   spi_fpga_regif dut (
      .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .fpga_cs(fpga_cs),
      .fpga_mosi(fpga_mosi), .fpga_miso(fpga_miso), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
      .reg_rdata(reg_rdata), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Register slave: read data is valid only during the cycle after the strobe.
   always begin
      @(posedge clk);
      #1;
      if (reg_rd_en) begin
         @(posedge clk);
         #1;
         reg_rdata = rd_value;
         @(posedge clk);
         #1;
         reg_rdata = 8'hEE;
      end
   end

   always @(negedge clk) begin
      if (reg_wr_en) begin
         wr_cnt++;
         last_wr_addr = reg_addr;
         last_wdata = reg_wdata;
      end
      if (reg_rd_en) begin
         rd_cnt++;
         last_rd_addr = reg_addr;
      end
      if (frame_err) err_cnt++;
      if (fpga_miso) miso_hi_cnt++;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Master drives MOSI mid-low-phase and samples MISO just before each rise.
   task automatic apply_stimulus(input logic [31:0] word, input int nbits, input int nrises,
                                 input bit release_cs, output logic [31:0] miso_bits);
      fpga_cs = 1'b0;
      #80;
      miso_bits = '0;
      for (int i = 0; i < nrises; i++) begin
         fpga_mosi = word[nbits-1-i];
         #40;
         miso_bits = {miso_bits[30:0], fpga_miso};
         spi_sclk = 1'b1;
         #80;
         spi_sclk = 1'b0;
         #40;
      end
      if (release_cs) begin
         #40;
         fpga_cs = 1'b1;
         #40;
      end
   endtask

   initial begin
      logic [31:0] bits;
      int w0, r0, e0, m0;

      #20;
      check_output("reset_outputs", {reg_addr, reg_wdata, reg_wr_en, reg_rd_en, frame_err, fpga_miso}, 32'h0);
      rst_n = 1'b1;
      #100;

      // Write 0x02A5
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; m0 = miso_hi_cnt;
      apply_stimulus(32'h02A5, 16, 16, 1'b1, bits);
      #100;
      check_output("wr_count", wr_cnt - w0, 1);
      check_output("wr_addr", last_wr_addr, 7'h02);
      check_output("wr_data", last_wdata, 8'hA5);
      check_output("wr_no_rd", rd_cnt - r0, 0);
      check_output("wr_no_err", err_cnt - e0, 0);
      check_output("wr_miso_bits", bits[15:0], 16'h0000);
      check_output("wr_miso_low", miso_hi_cnt - m0, 0);

      // Read 0x8300 returning 0x3C
      w0 = wr_cnt; r0 = rd_cnt; rd_value = 8'h3C;
      apply_stimulus(32'h8300, 16, 16, 1'b1, bits);
      #100;
      check_output("rd_count", rd_cnt - r0, 1);
      check_output("rd_addr", last_rd_addr, 7'h03);
      check_output("rd_miso_bits", bits[15:0], 16'h003C);
      check_output("rd_no_wr", wr_cnt - w0, 0);

      // Abort after 10 rises of a write
      w0 = wr_cnt; e0 = err_cnt;
      apply_stimulus(32'h0255, 16, 10, 1'b1, bits);
      #100;
      check_output("abort_err", err_cnt - e0, 1);
      check_output("abort_no_wr", wr_cnt - w0, 0);

      // Overlong frame: 0x0111 followed by four extra ones
      w0 = wr_cnt; e0 = err_cnt; m0 = miso_hi_cnt;
      apply_stimulus(32'h0111F, 20, 20, 1'b1, bits);
      #100;
      check_output("long_wr_count", wr_cnt - w0, 1);
      check_output("long_wr_addr", last_wr_addr, 7'h01);
      check_output("long_wr_data", last_wdata, 8'h11);
      check_output("long_no_err", err_cnt - e0, 0);
      check_output("long_miso_low", miso_hi_cnt - m0, 0);

      // Back-to-back write then read with 4 clk of CS high between
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; rd_value = 8'h77;
      apply_stimulus(32'h055A, 16, 16, 1'b1, bits);
      apply_stimulus(32'h8600, 16, 16, 1'b1, bits);
      #100;
      check_output("b2b_wr_count", wr_cnt - w0, 1);
      check_output("b2b_rd_count", rd_cnt - r0, 1);
      check_output("b2b_wr_addr", last_wr_addr, 7'h05);
      check_output("b2b_wr_data", last_wdata, 8'h5A);
      check_output("b2b_rd_addr", last_rd_addr, 7'h06);
      check_output("b2b_rd_miso", bits[15:0], 16'h0077);
      check_output("b2b_no_err", err_cnt - e0, 0);

      // Reset in the middle of a read, released with CS still low
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; rd_value = 8'h3C;
      apply_stimulus(32'h8300, 16, 12, 1'b0, bits);
      check_output("rst_pre_rd", rd_cnt - r0, 1);
      rst_n = 1'b0;
      #2;
      check_output("rst_outputs", {reg_addr, reg_wdata, reg_wr_en, reg_rd_en, frame_err, fpga_miso}, 32'h0);
      #38;
      rst_n = 1'b1;
      #100;
      fpga_cs = 1'b1;
      #100;
      check_output("rst_cs_rise_no_err", err_cnt - e0, 0);
      check_output("rst_no_wr", wr_cnt - w0, 0);
      apply_stimulus(32'h7FC3, 16, 16, 1'b1, bits);
      #100;
      check_output("post_rst_wr_count", wr_cnt - w0, 1);
      check_output("post_rst_wr_addr", last_wr_addr, 7'h7F);
      check_output("post_rst_wr_data", last_wdata, 8'hC3);
      check_output("post_rst_rd_count", rd_cnt - r0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
